// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage family.
//   DefaultDataW : default data width reused by sibling pipe stages
//   cnt_width()  : width of an occupancy counter able to hold 0..depth
//   ptr_inc()    : circular pointer advance with explicit wrap at depth-1
package pipe_pkg;

  localparam int unsigned DefaultDataW = 32;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/elastic_pipe_mem.sv
// Storage array for elastic_pipe: DEPTH x DATA_W registers, one synchronous write port and
// one asynchronous read port. Kept as its own block so a latch or macro array can replace it.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
module elastic_pipe_mem
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset; contents are only meaningful when counted valid.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_pipe.sv
// Elastic pipeline stage on the v/d/e handshake, holding up to DEPTH words in a circular buffer.
// Every output is decoded from flops, so there is no combinational path e_down -> e_up or
// v_up/d_up -> v_down/d_down. Adds an occupancy output and a synchronous flush.
//   clk, rst_n     : clock, asynchronous active-low reset
//   v_up, d_up     : upstream valid/data; e_up : space available to upstream
//   v_down, d_down : downstream valid/head data; e_down : downstream enable
//   flush          : synchronous clear of all entries (wins over push/pop)
//   count          : current occupancy 0..DEPTH
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v_up,
  input  logic [DATA_W-1:0] d_up,
  output logic              e_up,
  output logic              v_down,
  output logic [DATA_W-1:0] d_down,
  input  logic              e_down,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign e_up   = (count_q != CNT_W'(DEPTH));
  assign v_down = (count_q != '0);
  assign count  = count_q;

  // A flush cycle discards the offered word and suppresses any pop.
  assign push = v_up & e_up & ~flush;
  assign pop  = v_down & e_down & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (pop) begin
        rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  elastic_pipe_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (d_up),
    .raddr (rd_ptr_q),
    .rdata (d_down)
  );

endmodule

// File: tb/tb_elastic_pipe.sv
// Self-checking bench for elastic_pipe. Three instances (DEPTH 2, 3, 4) share clock and reset.
// A reference model keeps one plain queue of words per instance; a monitor compares the DUT
// outputs against it on every falling edge and then applies that cycle's transfers.
module tb_elastic_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  v_up = '0;
  logic [2:0]  e_down = '0;
  logic [2:0]  flush = '0;
  logic [2:0]  e_up;
  logic [2:0]  v_down;
  logic [31:0] d_up [3];
  logic [31:0] d_down [3];
  logic [1:0]  cnt2;
  logic [1:0]  cnt3;
  logic [2:0]  cnt4;

  int n_cmp = 0;
  int n_bad = 0;
  int n_timeout = 0;
  int n_timeout_seen = 0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  logic        prev_stall [3];
  logic [31:0] prev_d [3];

  always #5 clk = ~clk;

  elastic_pipe #(.DATA_W(32), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .v_up(v_up[0]), .d_up(d_up[0]), .e_up(e_up[0]),
    .v_down(v_down[0]), .d_down(d_down[0]), .e_down(e_down[0]), .flush(flush[0]), .count(cnt2)
  );
  elastic_pipe #(.DATA_W(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .v_up(v_up[1]), .d_up(d_up[1]), .e_up(e_up[1]),
    .v_down(v_down[1]), .d_down(d_down[1]), .e_down(e_down[1]), .flush(flush[1]), .count(cnt3)
  );
  elastic_pipe #(.DATA_W(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .v_up(v_up[2]), .d_up(d_up[2]), .e_up(e_up[2]),
    .v_down(v_down[2]), .d_down(d_down[2]), .e_down(e_down[2]), .flush(flush[2]), .count(cnt4)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int depth_of(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return 32'(cnt2);
      1:       return 32'(cnt3);
      default: return 32'(cnt4);
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qfront(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpush(input int i, input logic [31:0] w);
    case (i)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endfunction

  function automatic void qpop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void qclear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Monitor / scoreboard. Reset is checked 1ns after assertion, before any clock edge.
  initial begin
    int sz;
    int dp;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        for (int i = 0; i < 3; i++) begin
          dp = depth_of(i);
          check($sformatf("rst_count[D%0d]", dp), cnt_of(i), 32'd0);
          check($sformatf("rst_v_down[D%0d]", dp), 32'(v_down[i]), 32'd0);
          check($sformatf("rst_e_up[D%0d]", dp), 32'(e_up[i]), 32'd1);
          qclear(i);
          prev_stall[i] = 1'b0;
        end
      end else begin
        if (n_timeout != n_timeout_seen) begin
          check("handshake_timeout", 32'(n_timeout), 32'(n_timeout_seen));
          n_timeout_seen = n_timeout;
        end
        for (int i = 0; i < 3; i++) begin
          sz = qsize(i);
          dp = depth_of(i);
          check($sformatf("count_le_depth[D%0d]", dp), 32'(cnt_of(i) <= 32'(dp)), 32'd1);
          check($sformatf("count[D%0d]", dp), cnt_of(i), 32'(sz));
          check($sformatf("e_up[D%0d]", dp), 32'(e_up[i]), 32'(sz != dp));
          check($sformatf("v_down[D%0d]", dp), 32'(v_down[i]), 32'(sz != 0));
          if (prev_stall[i]) begin
            check($sformatf("stall_v_down[D%0d]", dp), 32'(v_down[i]), 32'd1);
            check($sformatf("stall_d_down[D%0d]", dp), d_down[i], prev_d[i]);
          end
          if (sz != 0) begin
            check($sformatf("d_down[D%0d]", dp), d_down[i], qfront(i));
          end
          // Apply this cycle's transfers as seen by the model.
          if (flush[i]) begin
            qclear(i);
          end else begin
            if (sz != 0 && e_down[i]) qpop(i);
            if (v_up[i] && sz != dp) qpush(i, d_up[i]);
          end
          prev_stall[i] = v_down[i] & ~e_down[i] & ~flush[i];
          prev_d[i]     = d_down[i];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word until the upstream handshake completes, with a cycle bound.
  task automatic offer(input int i, input logic [31:0] w);
    logic acc;
    int   guard;
    guard = 0;
    acc = 1'b0;
    v_up[i] = 1'b1;
    d_up[i] = w;
    while (!acc && guard < 20) begin
      acc = e_up[i];
      step();
      guard++;
    end
    if (!acc) n_timeout++;
    v_up[i] = 1'b0;
  endtask

  task automatic drain();
    v_up   = '0;
    flush  = '0;
    e_down = '1;
    repeat (8) step();
  endtask

  initial begin
    int sent;
    int guard;
    logic acc;
    for (int i = 0; i < 3; i++) d_up[i] = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset mid-stream with DEPTH=2 holding two words.
    e_down[0] = 1'b0;
    offer(0, 32'h11);
    offer(0, 32'h22);
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Streaming through DEPTH=2, both sides always enabled.
    e_down[0] = 1'b1;
    v_up[0]   = 1'b1;
    for (int k = 0; k < 100; k++) begin
      d_up[0] = 32'(k);
      step();
    end
    drain();

    // Backpressure fill of DEPTH=4, then release.
    e_down[2] = 1'b0;
    v_up[2]   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d_up[2] = 32'hA0 + 32'(k);
      step();
    end
    e_down[2] = 1'b1;
    offer(2, 32'hA4);
    offer(2, 32'hA5);
    drain();

    // Pointer wrap on DEPTH=3 with random downstream stalls.
    sent  = 0;
    guard = 0;
    while (sent < 40 && guard < 400) begin
      v_up[1]   = 1'b1;
      d_up[1]   = 32'h300 + 32'(sent);
      e_down[1] = 1'($urandom_range(0, 1));
      acc       = e_up[1];
      step();
      if (acc) sent++;
      guard++;
    end
    if (sent < 40) n_timeout++;
    drain();

    // Simultaneous push/pop attempt while DEPTH=2 is full.
    e_down[0] = 1'b0;
    offer(0, 32'h501);
    offer(0, 32'h502);
    e_down[0] = 1'b1;
    offer(0, 32'h503);
    drain();

    // Flush of DEPTH=4 at count 3 with a word offered in the same cycle.
    e_down[2] = 1'b0;
    offer(2, 32'h601);
    offer(2, 32'h602);
    offer(2, 32'h603);
    flush[2] = 1'b1;
    v_up[2]  = 1'b1;
    d_up[2]  = 32'hDEAD;
    step();
    flush[2] = 1'b0;
    v_up[2]  = 1'b0;
    step();
    e_down[2] = 1'b1;
    offer(2, 32'h604);
    drain();

    // Random traffic on all instances, with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        v_up[i]   = ($urandom_range(0, 99) < 70);
        e_down[i] = ($urandom_range(0, 99) < 60);
        flush[i]  = ($urandom_range(0, 99) < 3);
        d_up[i]   = $urandom;
      end
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
